// File: rtl/load_counter_n_if.sv
// Control/status bundle for load_counter_n.
// master: the agent driving load/count requests; slave: the counter itself.
interface load_counter_n_if #(
  parameter int WIDTH = 3
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             dir;
  logic             count_en;
  logic             clear;
  logic [WIDTH-1:0] count;
  logic             done;
  logic             tc;
  logic             busy;

  modport master (
    output load, load_val, dir, count_en, clear,
    input  count, done, tc, busy
  );

  modport slave (
    input  load, load_val, dir, count_en, clear,
    output count, done, tc, busy
  );
endinterface

// File: rtl/load_counter_n.sv
// Loadable up/down counter with IDLE/RUN/DONE sequencing.
// A load captures the start/terminal value and direction, then the counter
// steps once per enabled cycle until it hits terminal, emitting a one-cycle
// tc pulse on the cycle after the terminal edge.
// Build option: define LOAD_COUNTER_N_AUTORELOAD_EN to restart from the
// start value on a terminal edge instead of parking in DONE.
module load_counter_n #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  load_counter_n_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] term;
  logic             at_term;

  // Down counts finish at 0; up counts finish at the loaded value.
  assign term    = dir_q ? reload_q : '0;
  assign at_term = (count_q == term);

  // Next-state and datapath decode; priority is clear, then load, then count.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    dir_d    = dir_q;
    done_d   = done_q;
    tc_d     = 1'b0;
    if (bus.clear) begin
      state_d = IDLE;
      count_d = '0;
      done_d  = 1'b0;
    end else if (bus.load) begin
      // A load on a terminal edge pre-empts that edge, so tc stays low.
      reload_d = bus.load_val;
      dir_d    = bus.dir;
      state_d  = RUN;
      done_d   = 1'b0;
      count_d  = bus.dir ? '0 : bus.load_val;
    end else if (state_q == RUN && bus.count_en) begin
      if (at_term) begin
        tc_d = 1'b1;
`ifdef LOAD_COUNTER_N_AUTORELOAD_EN
        count_d = dir_q ? '0 : reload_q;
`else
        state_d = DONE;
        done_d  = 1'b1;
`endif
      end else begin
        count_d = dir_q ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
      end
    end
  end

  // State and output registers; reset aborts immediately, independent of clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      dir_q    <= 1'b0;
      done_q   <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      dir_q    <= dir_d;
      done_q   <= done_d;
      tc_q     <= tc_d;
    end
  end

  assign bus.count = count_q;
  assign bus.done  = done_q;
  assign bus.tc    = tc_q;
  assign bus.busy  = (state_q == RUN);

endmodule

// File: tb/tb_load_counter_n.sv
// Self-checking bench for load_counter_n (WIDTH=3): directed scenarios plus
// a randomized run scored against a behavioural model.
module tb_load_counter_n;
  localparam int W   = 3;
  localparam int MOD = 1 << W;
`ifdef LOAD_COUNTER_N_AUTORELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  load_counter_n_if #(.WIDTH(W)) bus ();

  load_counter_n #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: 0 idle, 1 run, 2 done
  int m_st, m_cnt, m_start, m_done, m_tc;
  bit m_up;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.load = 1'b0; bus.load_val = '0; bus.dir = 1'b0;
    bus.count_en = 1'b0; bus.clear = 1'b0;
  endtask

  task automatic do_load(input int val, input bit up);
    bus.load = 1'b1; bus.load_val = W'(val); bus.dir = up;
    tick();
    bus.load = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    idle_inputs();
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({bus.count, bus.done, bus.tc, bus.busy} !== 6'b0) begin
      bad++; $display("FAIL reset_outputs: got count=%0d done=%b tc=%b busy=%b want all 0",
                      bus.count, bus.done, bus.tc, bus.busy);
    end
    #10 reset_n = 1'b1;
    bus.count_en = 1'b1;
    repeat (3) begin
      tick();
      total++;
      if (bus.count !== 3'd0 || bus.busy !== 1'b0) begin
        bad++; $display("FAIL reset_idle_hold: got count=%0d busy=%b want 0/0", bus.count, bus.busy);
      end
    end
    bus.count_en = 1'b0;
  endtask

  task automatic test_count_down();
    do_load(5, 1'b0);
    total++;
    if (bus.count !== 3'd5 || bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.tc !== 1'b0) begin
      bad++; $display("FAIL down_load: got count=%0d busy=%b done=%b tc=%b want 5/1/0/0",
                      bus.count, bus.busy, bus.done, bus.tc);
    end
    bus.count_en = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      logic [W-1:0] ec;
      logic et, ed, eb;
      tick();
      ec = (e <= 5) ? W'(5 - e) : (AUTO ? W'(5) : W'(0));
      et = (e == 6);
      ed = (e == 6) && !AUTO;
      eb = !ed;
      total++;
      if (bus.count !== ec || bus.tc !== et || bus.done !== ed || bus.busy !== eb) begin
        bad++; $display("FAIL down_edge%0d: got count=%0d tc=%b done=%b busy=%b want %0d/%b/%b/%b",
                        e, bus.count, bus.tc, bus.done, bus.busy, ec, et, ed, eb);
      end
    end
    tick();
    total++;
    if (bus.tc !== 1'b0 || bus.done !== !AUTO) begin
      bad++; $display("FAIL down_after: got tc=%b done=%b want 0/%b", bus.tc, bus.done, !AUTO);
    end
    bus.count_en = 1'b0;
  endtask

  task automatic test_count_up();
    do_load(5, 1'b1);
    bus.dir = 1'b0;  // ignored while running
    total++;
    if (bus.count !== 3'd0 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL up_load: got count=%0d busy=%b want 0/1", bus.count, bus.busy);
    end
    bus.count_en = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      logic [W-1:0] ec;
      logic et, ed;
      tick();
      ec = (e <= 5) ? W'(e) : (AUTO ? W'(0) : W'(5));
      et = (e == 6);
      ed = (e == 6) && !AUTO;
      total++;
      if (bus.count !== ec || bus.tc !== et || bus.done !== ed) begin
        bad++; $display("FAIL up_edge%0d: got count=%0d tc=%b done=%b want %0d/%b/%b",
                        e, bus.count, bus.tc, bus.done, ec, et, ed);
      end
    end
    bus.count_en = 1'b0;
  endtask

  task automatic test_enable_gap_clear();
    logic [W-1:0] exp_c [4] = '{3'd2, 3'd2, 3'd1, 3'd1};
    do_load(3, 1'b0);
    total++;
    if (bus.count !== 3'd3) begin
      bad++; $display("FAIL gap_load: got count=%0d want 3", bus.count);
    end
    for (int i = 0; i < 4; i++) begin
      bus.count_en = (i % 2 == 0);
      tick();
      total++;
      if (bus.count !== exp_c[i]) begin
        bad++; $display("FAIL gap_step%0d: got count=%0d want %0d", i, bus.count, exp_c[i]);
      end
    end
    bus.count_en = 1'b1;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    total++;
    if (bus.count !== 3'd0 || bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.tc !== 1'b0) begin
      bad++; $display("FAIL gap_clear: got count=%0d done=%b busy=%b tc=%b want 0/0/0/0",
                      bus.count, bus.done, bus.busy, bus.tc);
    end
    tick();
    total++;
    if (bus.count !== 3'd0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL gap_idle_ignore: got count=%0d busy=%b want 0/0", bus.count, bus.busy);
    end
    bus.count_en = 1'b0;
  endtask

`ifdef LOAD_COUNTER_N_AUTORELOAD_EN
  task automatic test_autoreload();
    do_load(2, 1'b0);
    bus.count_en = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      logic [W-1:0] ec;
      logic et;
      tick();
      ec = W'(2 - (e % 3));
      et = (e % 3 == 0);
      total++;
      if (bus.count !== ec || bus.tc !== et || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
        bad++; $display("FAIL auto_edge%0d: got count=%0d tc=%b done=%b busy=%b want %0d/%b/0/1",
                        e, bus.count, bus.tc, bus.done, bus.busy, ec, et);
      end
    end
    bus.count_en = 1'b0;
  endtask
`endif

  task automatic test_load_zero();
    for (int d = 0; d < 2; d++) begin
      do_load(0, d[0]);
      bus.count_en = 1'b1;
      tick();
      bus.count_en = 1'b0;
      total++;
      if (bus.count !== 3'd0 || bus.tc !== 1'b1 || bus.done !== !AUTO) begin
        bad++; $display("FAIL zero_dir%0d: got count=%0d tc=%b done=%b want 0/1/%b",
                        d, bus.count, bus.tc, bus.done, !AUTO);
      end
    end
  endtask

  task automatic test_async_reset();
    do_load(7, 1'b0);
    bus.count_en = 1'b1;
    repeat (3) tick();
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({bus.count, bus.done, bus.tc, bus.busy} !== 6'b0) begin
      bad++; $display("FAIL async_reset: got count=%0d done=%b tc=%b busy=%b want all 0",
                      bus.count, bus.done, bus.tc, bus.busy);
    end
    #2 reset_n = 1'b1;
    repeat (3) tick();
    total++;
    if (bus.count !== 3'd0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL async_idle: got count=%0d busy=%b want 0/0", bus.count, bus.busy);
    end
    do_load(2, 1'b0);
    bus.count_en = 1'b0;
    total++;
    if (bus.count !== 3'd2 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL async_reload: got count=%0d busy=%b want 2/1", bus.count, bus.busy);
    end
  endtask

  task automatic test_load_at_terminal();
    do_load(3, 1'b0);
    bus.count_en = 1'b1;
    repeat (3) tick();
    total++;
    if (bus.count !== 3'd0 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL lat_reach0: got count=%0d busy=%b want 0/1", bus.count, bus.busy);
    end
    bus.load = 1'b1; bus.load_val = 3'd4; bus.dir = 1'b0;
    tick();
    bus.load = 1'b0;
    total++;
    if (bus.count !== 3'd4 || bus.tc !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL lat_load_wins: got count=%0d tc=%b done=%b busy=%b want 4/0/0/1",
                      bus.count, bus.tc, bus.done, bus.busy);
    end
    tick();
    total++;
    if (bus.count !== 3'd3) begin
      bad++; $display("FAIL lat_continue: got count=%0d want 3", bus.count);
    end
    bus.count_en = 1'b0;
  endtask

  task automatic test_random();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    m_st = 0; m_cnt = 0; m_start = 0; m_up = 1'b0; m_done = 0; m_tc = 0;
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] ec;
      bus.clear    = ($urandom_range(0, 99) < 4);
      bus.load     = ($urandom_range(0, 99) < 12);
      bus.load_val = W'($urandom_range(0, MOD - 1));
      bus.dir      = $urandom_range(0, 1) == 1;
      bus.count_en = ($urandom_range(0, 99) < 75);
      tick();
      // model: what the spec says happens on this edge
      if (bus.clear) begin
        m_st = 0; m_cnt = 0; m_done = 0; m_tc = 0;
      end else if (bus.load) begin
        m_start = int'(bus.load_val); m_up = bus.dir;
        m_st = 1; m_done = 0; m_tc = 0;
        m_cnt = m_up ? 0 : m_start;
      end else if (m_st == 1 && bus.count_en) begin
        if (m_cnt == (m_up ? m_start : 0)) begin
          m_tc = 1;
          if (AUTO) m_cnt = m_up ? 0 : m_start;
          else begin m_st = 2; m_done = 1; end
        end else begin
          m_tc = 0;
          m_cnt = (m_cnt + (m_up ? 1 : MOD - 1)) % MOD;
        end
      end else begin
        m_tc = 0;
      end
      ec = W'(m_cnt);
      total++;
      if (bus.count !== ec || bus.done !== m_done[0] || bus.tc !== m_tc[0] || bus.busy !== (m_st == 1)) begin
        bad++; $display("FAIL rand_cycle%0d: got count=%0d done=%b tc=%b busy=%b want %0d/%0d/%0d/%b",
                        i, bus.count, bus.done, bus.tc, bus.busy, ec, m_done, m_tc, (m_st == 1));
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_count_down();
    test_count_up();
    test_enable_gap_clear();
`ifdef LOAD_COUNTER_N_AUTORELOAD_EN
    test_autoreload();
`endif
    test_load_zero();
    test_async_reset();
    test_load_at_terminal();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_counter_n.md
LOAD_COUNTER_N -- requirements
Module: load_counter_n

Interface
REQ-001 Parameter: WIDTH, 3, counter and load-value width in bits (legal 2..32).
REQ-002 Port: clk  in  1  rising-edge clock; all state changes on this edge.
REQ-003 Port: reset_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: load  in  1  load request; samples load_val and dir.
REQ-005 Port: load_val  in  WIDTH  terminal/start value.
REQ-006 Port: dir  in  1  count direction at load: 0 = down, 1 = up.
REQ-007 Port: count_en  in  1  count enable; one step per enabled cycle.
REQ-008 Port: clear  in  1  synchronous abort to IDLE.
REQ-009 Port: count  out  WIDTH  current count value (registered).
REQ-010 Port: done  out  1  sticky completion flag (registered).
REQ-011 Port: tc  out  1  one-cycle terminal-count pulse (registered).
REQ-012 Port: busy  out  1  high while in RUN (registered or decoded from state).

Function
REQ-013 The block SHALL implement a state machine with states IDLE, RUN and DONE.
REQ-014 Edge priority SHALL be clear > load > count_en.
REQ-015 clear SHALL force IDLE, count=0, done=0 and tc=0, in any state.
REQ-016 load in any state SHALL latch reload_q=load_val and dir_q=dir, then enter RUN with done=0.
REQ-017 On load, count SHALL be set to load_val when dir=0, or to 0 when dir=1.
REQ-018 Terminal value SHALL be 0 when dir_q=0 and reload_q when dir_q=1.
REQ-019 In RUN with count_en=1 and count not terminal, count SHALL step by 1 (down: -1; up: +1), modulo 2^WIDTH.
REQ-020 In RUN with count_en=1 and count at terminal, tc SHALL be 1 for the following cycle only.
REQ-021 In the same case, the next state SHALL follow REQ-031/REQ-032.
REQ-022 In RUN with count_en=0, count SHALL hold.
REQ-023 In IDLE and DONE, count_en SHALL be ignored and count SHALL hold.
REQ-024 Latency: after load of N (down) with count_en held high, count SHALL reach 0 after N enabled edges.
REQ-025 In the same case, tc SHALL assert on enabled edge N+1.
REQ-026 load of 0 (either direction) SHALL reach terminal on the first enabled edge.
REQ-027 dir changes while in RUN SHALL have no effect; only dir_q is used.
REQ-028 busy SHALL be 1 exactly when the state is RUN.
REQ-029 tc SHALL be 0 in every cycle except those given in REQ-020.
REQ-030 load coincident with a terminal edge SHALL win: no tc, new value loaded.

Configuration
REQ-031 With macro LOAD_COUNTER_N_AUTORELOAD_EN defined, a terminal edge in RUN SHALL reload the start value and remain in RUN.
REQ-032 In that case the start value SHALL be reload_q for down and 0 for up, tc SHALL pulse, and done SHALL stay 0.
REQ-033 Without the macro, a terminal edge SHALL enter DONE with done=1 and count holding at terminal.
REQ-034 Without the macro, done SHALL remain 1 until load, clear or reset.

Reset
REQ-035 While reset_n=0, state SHALL be IDLE, count=0, done=0, tc=0, busy=0, reload_q=0 and dir_q=0.
REQ-036 Reset asserted mid-RUN SHALL abort immediately, without waiting for clk.
REQ-037 After reset_n deasserts, the block SHALL stay in IDLE until load.

Verification (WIDTH=3)
REQ-038 Bench SHALL cover: load 5, dir=0, count_en high -> count 5,4,3,2,1,0; tc pulse and done=1 on 6th edge; busy falls with done (macro off).
REQ-039 Bench SHALL cover: load 5, dir=1, count_en high -> count 0..5; tc on 6th edge; done=1 (macro off).
REQ-040 Bench SHALL cover: load 3 down, count_en toggled 1,0,1,0 -> count 3,2,2,1,1; clear on next edge -> IDLE, count=0, done=0.
REQ-041 Bench SHALL cover: macro on, load 2 down, count_en high for 9 edges -> count 2,1,0,2,1,0,2,1,0; tc on edges 3, 6 and 9; done stays 0.
REQ-042 Bench SHALL cover: load 7 down, reset_n low mid-count without clk -> all outputs 0 at once; after release, count_en ignored until load.
REQ-043 Bench SHALL cover: count at 0 in RUN, load 4 on the same edge as count_en -> count=4, tc=0, done=0.
